// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the sequencer and seq_alu.
// master = sequencer side, slave = ALU side.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] yhigh;
  logic [WIDTH-1:0] ylow;
  logic             n;
  logic             z;
  logic             dz;

  modport master (
    output start, s, a, b,
    input  busy, done, yhigh, ylow, n, z, dz
  );

  modport slave (
    input  start, s, a, b,
    output busy, done, yhigh, ylow, n, z, dz
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: signed ALU with iterative shift-add MUL and restoring DIV.
// Define SEQ_ALU_FAST_MUL_EN for a single-cycle combinational MUL.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          div_q, div_d;
  logic [2*W:0]  p_q, p_d;
  logic [W-1:0]  yh_q, yh_d;
  logic [W-1:0]  yl_q, yl_d;
  logic          n_q, n_d;
  logic          z_q, z_d;
  logic          dz_q, dz_d;

  logic [W-1:0]   ma, mb;
  logic [W:0]     mul_sum;
  logic [W:0]     div_r2, div_rem;
  logic           div_ge;
  logic [2*W-1:0] prod;
  logic [W-1:0]   q_fix, r_fix;
  logic [W:0]     sum_ext;
  logic [SW-1:0]  sh;
  logic [W-1:0]   sc_hi, sc_lo;
  logic           iter;
`ifdef SEQ_ALU_FAST_MUL_EN
  logic signed [2*W-1:0] fm;
`endif

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  // Datapath: p_q holds {hi, lo} for MUL and {rem, quo} for DIV.
  always_comb begin
    ma      = mag(a_q);
    mb      = mag(b_q);
    mul_sum = p_q[2*W:W] + (p_q[0] ? {1'b0, ma} : '0);
    div_r2  = {p_q[2*W-1:W], p_q[W-1]};
    div_ge  = (div_r2 >= {1'b0, mb});
    div_rem = div_ge ? (div_r2 - {1'b0, mb}) : div_r2;
    prod    = (a_q[W-1] ^ b_q[W-1]) ? -p_q[2*W-1:0]
                                    : p_q[2*W-1:0];
    if (b_q == '0) begin
      q_fix = '1;
      r_fix = a_q;
    end else begin
      q_fix = (a_q[W-1] ^ b_q[W-1]) ? -p_q[W-1:0] : p_q[W-1:0];
      r_fix = a_q[W-1] ? -p_q[2*W-1:W] : p_q[2*W-1:W];
    end
  end

  always_comb begin
    sh      = bus.b[SW-1:0];
    sum_ext = '0;
    sc_hi   = '0;
    sc_lo   = '0;
`ifdef SEQ_ALU_FAST_MUL_EN
    fm      = $signed(bus.a) * $signed(bus.b);
    iter    = (bus.s == OP_DIV);
`else
    iter    = (bus.s == OP_MUL) || (bus.s == OP_DIV);
`endif
    unique case (1'b1)
      (bus.s == OP_ADD): begin
        sum_ext = {bus.a[W-1], bus.a} + {bus.b[W-1], bus.b};
        sc_lo   = sum_ext[W-1:0];
        sc_hi   = {W{sum_ext[W]}};
      end
      (bus.s == OP_SUB): begin
        sum_ext = {bus.a[W-1], bus.a} - {bus.b[W-1], bus.b};
        sc_lo   = sum_ext[W-1:0];
        sc_hi   = {W{sum_ext[W]}};
      end
      (bus.s == OP_AND): begin
        sc_lo = bus.a & bus.b;
        sc_hi = {W{sc_lo[W-1]}};
      end
      (bus.s == OP_OR): begin
        sc_lo = bus.a | bus.b;
        sc_hi = {W{sc_lo[W-1]}};
      end
      (bus.s == OP_SLL): begin
        sc_lo = bus.a << sh;
        sc_hi = {W{sc_lo[W-1]}};
      end
      (bus.s == OP_SRA): begin
        sc_lo = $signed(bus.a) >>> sh;
        sc_hi = {W{sc_lo[W-1]}};
      end
`ifdef SEQ_ALU_FAST_MUL_EN
      (bus.s == OP_MUL): begin
        sc_hi = fm[2*W-1:W];
        sc_lo = fm[W-1:0];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    p_d     = p_q;
    yh_d    = yh_q;
    yl_d    = yl_q;
    n_d     = n_q;
    z_d     = z_q;
    dz_d    = dz_q;
    unique case (state_q)
      RUN: begin
        if (cnt_q != CW'(W)) begin
          cnt_d = cnt_q + CW'(1);
          p_d   = div_q ? {div_rem, p_q[W-2:0], div_ge}
                        : {1'b0, mul_sum, p_q[W-1:1]};
        end else begin
          // Last RUN cycle doubles as the sign-fixup step.
          state_d = DONE;
          if (div_q) begin
            yh_d = r_fix;
            yl_d = q_fix;
            n_d  = q_fix[W-1];
            z_d  = (q_fix == '0);
            dz_d = (b_q == '0);
          end else begin
            {yh_d, yl_d} = prod;
            n_d  = prod[2*W-1];
            z_d  = (prod == '0);
            dz_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          div_d = (bus.s == OP_DIV);
          cnt_d = '0;
          if (iter) begin
            state_d = RUN;
            p_d = {{(W+1){1'b0}},
                   (bus.s == OP_DIV) ? mag(bus.a) : mag(bus.b)};
          end else begin
            state_d = DONE;
            yh_d = sc_hi;
            yl_d = sc_lo;
            n_d  = sc_hi[W-1];
            z_d  = ({sc_hi, sc_lo} == '0);
            dz_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      p_q     <= '0;
      yh_q    <= '0;
      yl_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      p_q     <= p_d;
      yh_q    <= yh_d;
      yl_q    <= yl_d;
      n_q     <= n_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.yhigh = yh_q;
  assign bus.ylow  = yl_q;
  assign bus.n     = n_q;
  assign bus.z     = z_q;
  assign bus.dz    = dz_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=16.
// Expected values are hand-computed per scenario.
module tb_seq_alu;
`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 18;
`endif
  localparam int DIV_LAT = 18;

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;

  seq_alu_if #(.WIDTH(16)) bus ();

  seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] op, input logic [15:0] av,
                       input logic [15:0] bv, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.s     = op;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.s     = 3'd7;
    bus.a     = 16'h5a5a;
    bus.b     = 16'ha5a5;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.s = 3'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 00", {bus.busy, bus.done});
    end
    checks++;
    if ({bus.yhigh, bus.ylow, bus.n, bus.z, bus.dz} !== 35'd0) begin
      errs++;
      $display("FAIL reset_out: got %h %h %b%b%b want 0",
               bus.yhigh, bus.ylow, bus.n, bus.z, bus.dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep;
    int lat;
    logic [15:0] lo_t [8];
    logic        z_t [8];
    int          lat_t [8];
    lo_t  = '{16'd15, 16'd5, 16'd50, 16'd2, 16'd0, 16'd15, 16'd320, 16'd0};
    z_t   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    lat_t = '{1, 1, MUL_LAT, DIV_LAT, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(i[2:0], 16'd10, 16'd5, lat);
      checks++;
      if (lat != lat_t[i]) begin
        errs++;
        $display("FAIL sweep_lat s=%0d: got %0d want %0d", i, lat, lat_t[i]);
      end
      checks++;
      if ({bus.yhigh, bus.ylow} !== {16'h0, lo_t[i]}) begin
        errs++;
        $display("FAIL sweep_res s=%0d: got %h_%h want 0000_%h",
                 i, bus.yhigh, bus.ylow, lo_t[i]);
      end
      checks++;
      if ({bus.n, bus.z, bus.dz} !== {1'b0, z_t[i], 1'b0}) begin
        errs++;
        $display("FAIL sweep_flags s=%0d: got %b%b%b want 0%b0",
                 i, bus.n, bus.z, bus.dz, z_t[i]);
      end
    end
  endtask

  task automatic test_mul_div;
    int lat;
    do_op(3'd2, 16'd1001, 16'd1001, lat);
    checks++;
    if ({bus.yhigh, bus.ylow, bus.n, bus.z} !== {16'd15, 16'd18961, 2'b00}) begin
      errs++;
      $display("FAIL mul_1001sq: got %0d %0d n%b z%b want 15 18961 n0 z0",
               bus.yhigh, bus.ylow, bus.n, bus.z);
    end
    checks++;
    if (lat != MUL_LAT) begin
      errs++;
      $display("FAIL mul_lat: got %0d want %0d", lat, MUL_LAT);
    end
    do_op(3'd3, 16'hfff9, 16'd2, lat);
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'hffff, 16'hfffd}) begin
      errs++;
      $display("FAIL div_neg7_2: got %h_%h want ffff_fffd",
               bus.yhigh, bus.ylow);
    end
    checks++;
    if ({bus.n, bus.z, bus.dz} !== 3'b100) begin
      errs++;
      $display("FAIL div_neg7_flags: got %b%b%b want 100",
               bus.n, bus.z, bus.dz);
    end
    do_op(3'd2, 16'hfffd, 16'd4, lat);
    checks++;
    if ({bus.yhigh, bus.ylow, bus.n} !== {16'hffff, 16'hfff4, 1'b1}) begin
      errs++;
      $display("FAIL mul_neg3_4: got %h_%h n%b want ffff_fff4 n1",
               bus.yhigh, bus.ylow, bus.n);
    end
  endtask

  task automatic test_shift;
    int lat;
    do_op(3'd6, 16'd1, 16'h0013, lat);
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'h0, 16'd8}) begin
      errs++;
      $display("FAIL sll_amt_mask: got %h_%h want 0000_0008",
               bus.yhigh, bus.ylow);
    end
    do_op(3'd7, 16'hfff0, 16'h0022, lat);
    checks++;
    if ({bus.yhigh, bus.ylow, bus.n} !== {16'hffff, 16'hfffc, 1'b1}) begin
      errs++;
      $display("FAIL sra_neg: got %h_%h n%b want ffff_fffc n1",
               bus.yhigh, bus.ylow, bus.n);
    end
  endtask

  task automatic test_add_boundary;
    int lat;
    do_op(3'd0, 16'd32767, 16'd1, lat);
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'h0000, 16'h8000}) begin
      errs++;
      $display("FAIL add_max: got %h_%h want 0000_8000", bus.yhigh, bus.ylow);
    end
    checks++;
    if ({bus.n, bus.z} !== 2'b00) begin
      errs++;
      $display("FAIL add_max_flags: got n%b z%b want n0 z0", bus.n, bus.z);
    end
    do_op(3'd1, 16'd0, 16'd0, lat);
    checks++;
    if ({bus.yhigh, bus.ylow} !== 32'h0) begin
      errs++;
      $display("FAIL sub_zero: got %h_%h want 0", bus.yhigh, bus.ylow);
    end
    checks++;
    if ({bus.n, bus.z} !== 2'b01) begin
      errs++;
      $display("FAIL sub_zero_flags: got n%b z%b want n0 z1", bus.n, bus.z);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    do_op(3'd3, 16'd1001, 16'd0, lat);
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'd1001, 16'hffff}) begin
      errs++;
      $display("FAIL div0_res: got %h_%h want 03e9_ffff", bus.yhigh, bus.ylow);
    end
    checks++;
    if ({bus.n, bus.z, bus.dz} !== 3'b101) begin
      errs++;
      $display("FAIL div0_flags: got %b%b%b want 101", bus.n, bus.z, bus.dz);
    end
    do_op(3'd0, 16'd1, 16'd1, lat);
    checks++;
    if (bus.dz !== 1'b0) begin
      errs++;
      $display("FAIL dz_clear: got %b want 0", bus.dz);
    end
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'h0, 16'd2}) begin
      errs++;
      $display("FAIL add_1_1: got %h_%h want 0000_0002", bus.yhigh, bus.ylow);
    end
  endtask

  task automatic test_busy_ignore;
    int c, first, nd;
    @(negedge clk);
    bus.start = 1'b1;
    bus.s = 3'd2;
    bus.a = 16'd3;
    bus.b = 16'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    c = 1;
    first = 0;
    nd = 0;
    while (c <= 40 && nd == 0) begin
      if (bus.done) begin
        nd++;
        first = c;
      end else begin
        if (c == 4) begin
          bus.start = 1'b1;
          bus.s = 3'd0;
          bus.a = 16'd100;
          bus.b = 16'd100;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c++;
      end
    end
    checks++;
    if (first != MUL_LAT) begin
      errs++;
      $display("FAIL busy_done_at: got %0d want %0d", first, MUL_LAT);
    end
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'h0, 16'd12}) begin
      errs++;
      $display("FAIL busy_mul_res: got %h_%h want 0000_000c",
               bus.yhigh, bus.ylow);
    end
    bus.start = 1'b1;
    bus.s = 3'd0;
    bus.a = 16'd2;
    bus.b = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.yhigh, bus.ylow} !== {1'b1, 16'h0, 16'd5}) begin
      errs++;
      $display("FAIL b2b_add: got done%b %h_%h want done1 0000_0005",
               bus.done, bus.yhigh, bus.ylow);
    end
  endtask

  task automatic test_reset_abort;
    int nd, lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.s = 3'd3;
    bus.a = 16'd1001;
    bus.b = 16'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errs++;
      $display("FAIL abort_ctl: got %b want 00", {bus.busy, bus.done});
    end
    checks++;
    if ({bus.yhigh, bus.ylow, bus.n, bus.z, bus.dz} !== 35'd0) begin
      errs++;
      $display("FAIL abort_out: got %h_%h %b%b%b want 0",
               bus.yhigh, bus.ylow, bus.n, bus.z, bus.dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errs++;
      $display("FAIL abort_no_done: got %0d dones want 0", nd);
    end
    do_op(3'd3, 16'h8000, 16'hffff, lat);
    checks++;
    if ({bus.yhigh, bus.ylow} !== {16'h0000, 16'h8000}) begin
      errs++;
      $display("FAIL div_min_m1: got %h_%h want 0000_8000",
               bus.yhigh, bus.ylow);
    end
    checks++;
    if ({bus.n, bus.z, bus.dz, lat} !== {3'b100, DIV_LAT}) begin
      errs++;
      $display("FAIL div_min_flags: got %b%b%b lat %0d want 100 lat %0d",
               bus.n, bus.z, bus.dz, lat, DIV_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mul_div();
    test_shift();
    test_add_boundary();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
